// File: rtl/sha1_ctrl_pkg.sv
// Shared types and constants for the SHA-1 block sequencer and its round counter.
package sha1_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_INIT     = 3'b001,
    ST_COMPUTE  = 3'b010,
    ST_UPDATE   = 3'b011,
    ST_WAIT_BLK = 3'b100,
    ST_DONE     = 3'b101
  } state_e;

  localparam int unsigned ROUNDS_DEFAULT  = 80;
  localparam int unsigned W_DIRECT_ROUNDS = 16;

  localparam logic [1:0] F_CH      = 2'd0;
  localparam logic [1:0] F_PARITY  = 2'd1;
  localparam logic [1:0] F_MAJ     = 2'd2;
  localparam logic [1:0] F_PARITY2 = 2'd3;

  function automatic int unsigned stage_len(input int unsigned rounds);
    return rounds / 4;
  endfunction

  localparam int unsigned STAGE_LEN = stage_len(ROUNDS_DEFAULT);

endpackage

// File: rtl/sha1_block_sequencer_if.sv
// Host/datapath control bundle of the SHA-1 block sequencer.
interface sha1_block_sequencer_if #(
  parameter int unsigned ROUNDS = 80,
  parameter int unsigned UNROLL = 1,
  parameter int unsigned CNT_W  = $clog2(ROUNDS)
);
  logic              start_hash;
  logic              block_valid;
  logic              last_block;
  logic              abort;
  logic [2:0]        state;
  logic [CNT_W-1:0]  round;
  logic [1:0]        f_sel;
  logic [UNROLL-1:0] w_load_mask;
  logic              round_en;
  logic              init_h;
  logic              block_ack;
  logic              add_h;
  logic              busy;
  logic              done;

  modport master (
    output start_hash, block_valid, last_block, abort,
    input  state, round, f_sel, w_load_mask, round_en,
           init_h, block_ack, add_h, busy, done
  );

  modport slave (
    input  start_hash, block_valid, last_block, abort,
    output state, round, f_sel, w_load_mask, round_en,
           init_h, block_ack, add_h, busy, done
  );
endinterface

// File: rtl/sha1_round_counter.sv
// Round group counter with combinational round-function select and W-source mask.
module sha1_round_counter
  import sha1_ctrl_pkg::*;
#(
  parameter int unsigned ROUNDS = ROUNDS_DEFAULT,
  parameter int unsigned UNROLL = 1,
  parameter int unsigned CNT_W  = $clog2(ROUNDS)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              clear,
  input  logic              advance,
  output logic [CNT_W-1:0]  round,
  output logic              last_group,
  output logic [1:0]        f_sel,
  output logic [UNROLL-1:0] w_load_mask
);

  localparam int unsigned STAGE = stage_len(ROUNDS);

  logic [CNT_W-1:0] r_round;
  logic             w_last_group;

  assign w_last_group = (r_round == CNT_W'(ROUNDS - UNROLL));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_round <= '0;
    end else if (clear || (advance && w_last_group)) begin
      r_round <= '0;
    end else if (advance) begin
      r_round <= r_round + CNT_W'(UNROLL);
    end
  end

  always_comb begin
    f_sel = F_CH;
    if (r_round >= CNT_W'(3 * STAGE)) begin
      f_sel = F_PARITY2;
    end else if (r_round >= CNT_W'(2 * STAGE)) begin
      f_sel = F_MAJ;
    end else if (r_round >= CNT_W'(STAGE)) begin
      f_sel = F_PARITY;
    end
  end

  for (genvar g = 0; g < UNROLL; g++) begin : g_mask
    assign w_load_mask[g] = ((32'(r_round) + 32'(g)) < W_DIRECT_ROUNDS);
  end

  assign round      = r_round;
  assign last_group = w_last_group;

endmodule

// File: rtl/sha1_block_sequencer.sv
// SHA-1 multi-block control FSM: init, round sequencing, H update, chaining, abort.
module sha1_block_sequencer
  import sha1_ctrl_pkg::*;
#(
  parameter int unsigned ROUNDS = ROUNDS_DEFAULT,
  parameter int unsigned UNROLL = 1,
  parameter int unsigned CNT_W  = $clog2(ROUNDS)
) (
  input logic                   clk,
  input logic                   nreset,
  sha1_block_sequencer_if.slave bus
);

  state_e            r_state;
  state_e            w_next;
  logic              r_start_armed;
  logic              r_last;
  logic              w_start_rise;
  logic              w_last_group;
  logic              w_clear;
  logic              w_advance;
  logic [CNT_W-1:0]  w_round;
  logic [1:0]        w_f_sel;
  logic [UNROLL-1:0] w_mask;
  logic              w_round_en;
  logic              w_init_h;
  logic              w_block_ack;
  logic              w_add_h;
  logic              w_done;
  logic              w_busy;

  // Armed means start was seen low; reset disarms so a level held through reset never starts.
  assign w_start_rise = bus.start_hash && r_start_armed;
  assign w_clear      = bus.abort || (r_state != ST_COMPUTE);
  assign w_advance    = (r_state == ST_COMPUTE);

  sha1_round_counter #(
    .ROUNDS (ROUNDS),
    .UNROLL (UNROLL),
    .CNT_W  (CNT_W)
  ) u_round_counter (
    .clk         (clk),
    .nreset      (nreset),
    .clear       (w_clear),
    .advance     (w_advance),
    .round       (w_round),
    .last_group  (w_last_group),
    .f_sel       (w_f_sel),
    .w_load_mask (w_mask)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state       <= ST_IDLE;
      r_start_armed <= 1'b0;
      r_last        <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_start_armed <= ~bus.start_hash;
      if (w_block_ack) begin
        r_last <= bus.last_block;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_start_rise) w_next = ST_INIT;
      ST_INIT:     w_next = ST_COMPUTE;
      ST_COMPUTE:  if (w_last_group) w_next = ST_UPDATE;
      ST_UPDATE:   w_next = r_last ? ST_DONE : ST_WAIT_BLK;
      ST_WAIT_BLK: if (bus.block_valid) w_next = ST_COMPUTE;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
    if (bus.abort) begin
      w_next = ST_IDLE;
    end
  end

  always_comb begin
    w_round_en  = 1'b0;
    w_init_h    = 1'b0;
    w_block_ack = 1'b0;
    w_add_h     = 1'b0;
    w_done      = 1'b0;
    w_busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_INIT: begin
        w_init_h    = 1'b1;
        w_block_ack = 1'b1;
      end
      ST_COMPUTE:  w_round_en  = 1'b1;
      ST_UPDATE:   w_add_h     = 1'b1;
      ST_WAIT_BLK: w_block_ack = bus.block_valid;
      ST_DONE:     w_done      = 1'b1;
      default:     ;
    endcase
    if (bus.abort) begin
      w_init_h    = 1'b0;
      w_block_ack = 1'b0;
      w_add_h     = 1'b0;
      w_done      = 1'b0;
    end
  end

  assign bus.state       = r_state;
  assign bus.round       = w_round;
  assign bus.f_sel       = w_f_sel;
  assign bus.w_load_mask = w_mask;
  assign bus.round_en    = w_round_en;
  assign bus.init_h      = w_init_h;
  assign bus.block_ack   = w_block_ack;
  assign bus.add_h       = w_add_h;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;

endmodule

// File: tb/tb_sha1_block_sequencer.sv
// Scoreboard bench for sha1_block_sequencer: UNROLL=1 and UNROLL=5 instances.
module tb_sha1_block_sequencer;
  import sha1_ctrl_pkg::*;

  typedef struct {
    int         cyc;
    logic [4:0] kind;   // {init_h, block_ack, round_en, add_h, done}
    logic [6:0] round;
    logic [1:0] fsel;
    logic [4:0] mask;
  } exp_t;

  localparam logic [4:0] K_INIT = 5'b11000;
  localparam logic [4:0] K_ACK  = 5'b01000;
  localparam logic [4:0] K_REN  = 5'b00100;
  localparam logic [4:0] K_ADD  = 5'b00010;
  localparam logic [4:0] K_DONE = 5'b00001;

  logic clk = 1'b0;
  logic nreset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   t;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha1_block_sequencer_if #(.ROUNDS(80), .UNROLL(1)) bus0 ();
  sha1_block_sequencer_if #(.ROUNDS(80), .UNROLL(5)) bus1 ();

  sha1_block_sequencer #(.ROUNDS(80), .UNROLL(1)) dut0 (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus0)
  );

  sha1_block_sequencer #(.ROUNDS(80), .UNROLL(5)) dut1 (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int dut, input int c, input logic [4:0] kind, input int rnd, input int u);
    exp_t e;
    e.cyc   = c;
    e.kind  = kind;
    e.round = 7'(rnd);
    e.fsel  = 2'(rnd / STAGE_LEN);
    e.mask  = '0;
    for (int i = 0; i < u; i++) e.mask[i] = ((rnd + i) < 16);
    if (dut == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic push_rounds(input int dut, input int c0, input int r_last, input int u);
    for (int r = 0; r <= r_last; r += u) push(dut, c0 + r / u, K_REN, r, u);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mon_step(input int dut, input logic [4:0] kind, input logic [6:0] rnd,
                          input logic [1:0] fs, input logic [4:0] mk);
    exp_t        e;
    logic [18:0] o;
    logic [18:0] x;
    if (kind == 5'b0) return;
    if ((dut == 0 && q0.size() == 0) || (dut == 1 && q1.size() == 0)) begin
      n_chk++;
      n_err++;
      $display("FAIL dut%0d_unexpected: got outputs %b at cycle %0d, required none", dut, kind, cyc);
      return;
    end
    e = (dut == 0) ? q0.pop_front() : q1.pop_front();
    x = {e.kind, e.kind[2] ? {e.round, e.fsel, e.mask} : 14'd0};
    o = {kind,   e.kind[2] ? {rnd, fs, mk}             : 14'd0};
    chk((dut == 0) ? "dut0_evt{cyc,outs}" : "dut1_evt{cyc,outs}",
        {1'b0, cyc[11:0], o}, {1'b0, e.cyc[11:0], x});
  endtask

  always @(negedge clk) begin
    mon_step(0, {bus0.init_h, bus0.block_ack, bus0.round_en, bus0.add_h, bus0.done},
             bus0.round, bus0.f_sel, {4'b0, bus0.w_load_mask});
    mon_step(1, {bus1.init_h, bus1.block_ack, bus1.round_en, bus1.add_h, bus1.done},
             bus1.round, bus1.f_sel, bus1.w_load_mask);
    if (bus0.round_en) begin
      case (bus0.round)
        7'd15: chk("d0_mask_r15", bus0.w_load_mask, 1'b1);
        7'd16: chk("d0_mask_r16", bus0.w_load_mask, 1'b0);
        7'd19: chk("d0_fsel_r19", bus0.f_sel, 2'd0);
        7'd20: chk("d0_fsel_r20", bus0.f_sel, 2'd1);
        7'd40: chk("d0_fsel_r40", bus0.f_sel, 2'd2);
        7'd60: chk("d0_fsel_r60", bus0.f_sel, 2'd3);
        default: ;
      endcase
    end
    if (bus1.round_en) begin
      case (bus1.round)
        7'd10: chk("d1_mask_r10", bus1.w_load_mask, 5'b11111);
        7'd15: chk("d1_mask_r15", bus1.w_load_mask, 5'b00001);
        7'd20: chk("d1_mask_r20", bus1.w_load_mask, 5'b00000);
        default: ;
      endcase
    end
  end

  initial begin
    nreset = 1'b0;
    {bus0.start_hash, bus0.block_valid, bus0.last_block, bus0.abort} = 4'b0;
    {bus1.start_hash, bus1.block_valid, bus1.last_block, bus1.abort} = 4'b0;
    #12;
    chk("reset_state0", bus0.state, 3'b000);
    chk("reset_busy0", bus0.busy, 1'b0);
    chk("reset_round0", bus0.round, 7'd0);
    chk("reset_pulses0", {bus0.round_en, bus0.init_h, bus0.block_ack, bus0.add_h, bus0.done}, 5'b0);
    chk("reset_state1", bus1.state, 3'b000);
    #8 nreset = 1'b1;
    @(posedge clk);
    #1;
    wait_cyc(cyc + 3);

    // Single block, UNROLL=1
    bus0.last_block = 1'b1; bus0.block_valid = 1'b1; bus0.start_hash = 1'b1; t = cyc;
    push(0, t + 1, K_INIT, 0, 1);
    push_rounds(0, t + 2, 79, 1);
    push(0, t + 82, K_ADD, 0, 1);
    push(0, t + 83, K_DONE, 0, 1);
    wait_cyc(t + 2);  bus0.start_hash = 1'b0;
    wait_cyc(t + 84);
    chk("one_blk_busy_low", bus0.busy, 1'b0);
    chk("one_blk_idle", bus0.state, 3'b000);

    // Two blocks with a 5-cycle block gap
    wait_cyc(t + 86);
    bus0.last_block = 1'b0; bus0.block_valid = 1'b0; bus0.start_hash = 1'b1; t = cyc;
    push(0, t + 1, K_INIT, 0, 1);
    push_rounds(0, t + 2, 79, 1);
    push(0, t + 82, K_ADD, 0, 1);
    push(0, t + 88, K_ACK, 0, 1);
    push_rounds(0, t + 89, 79, 1);
    push(0, t + 169, K_ADD, 0, 1);
    push(0, t + 170, K_DONE, 0, 1);
    wait_cyc(t + 2);  bus0.start_hash = 1'b0;
    wait_cyc(t + 85);
    chk("two_blk_wait_state", bus0.state, 3'b100);
    chk("two_blk_wait_busy", bus0.busy, 1'b1);
    wait_cyc(t + 88); bus0.block_valid = 1'b1; bus0.last_block = 1'b1;
    wait_cyc(t + 89); bus0.block_valid = 1'b0; bus0.last_block = 1'b0;
    wait_cyc(t + 171);
    chk("two_blk_idle", bus0.state, 3'b000);

    // Single block, UNROLL=5
    wait_cyc(t + 173);
    bus1.last_block = 1'b1; bus1.start_hash = 1'b1; t = cyc;
    push(1, t + 1, K_INIT, 0, 5);
    push_rounds(1, t + 2, 75, 5);
    push(1, t + 18, K_ADD, 0, 5);
    push(1, t + 19, K_DONE, 0, 5);
    wait_cyc(t + 2);  bus1.start_hash = 1'b0;
    wait_cyc(t + 20);
    chk("u5_busy_low", bus1.busy, 1'b0);

    // Abort at round 40 with start held high afterwards
    wait_cyc(t + 22);
    bus0.last_block = 1'b1; bus0.start_hash = 1'b1; t = cyc;
    push(0, t + 1, K_INIT, 0, 1);
    push_rounds(0, t + 2, 40, 1);
    wait_cyc(t + 42); bus0.abort = 1'b1;
    wait_cyc(t + 43); bus0.abort = 1'b0;
    chk("abort_idle", bus0.state, 3'b000);
    chk("abort_round0", bus0.round, 7'd0);
    chk("abort_busy_low", bus0.busy, 1'b0);
    wait_cyc(t + 53);
    chk("abort_no_restart", bus0.state, 3'b000);
    bus0.start_hash = 1'b0;

    // Fresh edge restarts; abort during UPDATE suppresses add_h and done
    wait_cyc(t + 55); bus0.start_hash = 1'b1; t = cyc;
    push(0, t + 1, K_INIT, 0, 1);
    push_rounds(0, t + 2, 79, 1);
    wait_cyc(t + 82);
    chk("upd_abort_state", bus0.state, 3'b011);
    bus0.abort = 1'b1;
    wait_cyc(t + 83); bus0.abort = 1'b0;
    chk("upd_abort_idle", bus0.state, 3'b000);
    bus0.start_hash = 1'b0;

    // Asynchronous reset mid-COMPUTE, start held high through release
    wait_cyc(t + 85); bus0.start_hash = 1'b1; t = cyc;
    push(0, t + 1, K_INIT, 0, 1);
    push_rounds(0, t + 2, 10, 1);
    wait_cyc(t + 12);
    @(negedge clk);
    #1 nreset = 1'b0;
    #1;
    chk("async_rst_state", bus0.state, 3'b000);
    chk("async_rst_busy", bus0.busy, 1'b0);
    chk("async_rst_round", bus0.round, 7'd0);
    chk("async_rst_pulses", {bus0.round_en, bus0.init_h, bus0.block_ack, bus0.add_h, bus0.done}, 5'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 nreset = 1'b1;
    @(posedge clk);
    #1;
    t = cyc;
    wait_cyc(t + 10);
    chk("rst_release_no_start", bus0.state, 3'b000);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sha1_block_sequencer.md
Name: sha1_block_sequencer

Overview:
- Clocked control FSM for the SHA-1 core; sequences multi-block hashing end to end.
- Per 512-bit block: loads the initial H, counts rounds, orders the final H addition and hands off to the next block.
- Generalises the existing start/initialise/compute controller with:
  - registered state and a round counter;
  - round-unroll parameter;
  - multi-block chaining, abort and a done pulse.
- Sits between the host interface (start, block handshake) and the datapath (message schedule, round logic, H registers).

Parameters:
ROUNDS, 80, total rounds per block; must be a multiple of UNROLL and of 4
UNROLL, 1, rounds computed per clock; legal 1, 2, 4, 5 (must divide ROUNDS/4)
CNT_W, $clog2(ROUNDS), round counter width

Ports:
clk  in  1  system clock, rising edge
nreset  in  1  asynchronous active-low reset
start_hash  in  1  start request; rising edge sampled in IDLE
block_valid  in  1  next message block present at datapath input
last_block  in  1  current block is final; sampled when block_ack=1
abort  in  1  synchronous abort, returns to IDLE
state  out  3  current FSM state encoding
round  out  CNT_W  index of first round in current cycle's group
f_sel  out  2  round-function select: round/(ROUNDS/4)
w_load_mask  out  UNROLL  bit i = 1 when (round+i) < 16: take W from block, else expand
round_en  out  1  datapath performs round group this cycle
init_h  out  1  load H0..H4 initial constants (one-cycle pulse)
block_ack  out  1  block consumed, latch block into schedule (one-cycle pulse)
add_h  out  1  H += {a,b,c,d,e} (one-cycle pulse)
busy  out  1  high in every state except IDLE
done  out  1  digest valid, one-cycle pulse

Behaviour:
- Reset (nreset=0, asynchronous):
  - state=IDLE; round=0; all pulse outputs, busy and done = 0;
  - start_hash edge register cleared; last-block flag cleared.
  - Reset mid-operation abandons the hash; no done is produced.
- States: IDLE=000, INIT=001, COMPUTE=010, UPDATE=011, WAIT_BLK=100, DONE=101. Codes 110/111 go to IDLE next cycle.
- IDLE: start rising edge (start_hash=1, previous sample 0) -> INIT. A level held high from reset or from a previous run does not restart.
- INIT (1 cycle):
  - init_h=1, block_ack=1; last_block latched; round cleared to 0; -> COMPUTE.
  - block_valid is not checked: the first block must be present with start.
- COMPUTE:
  - round_en=1; round advances by UNROLL each cycle, starting at 0.
  - f_sel and w_load_mask are combinational from round.
  - UNROLL divides ROUNDS/4, so a round group never straddles an f_sel boundary.
  - When round = ROUNDS-UNROLL: round -> 0 and state -> UPDATE.
- UPDATE (1 cycle): add_h=1; if latched last_block=1 -> DONE, else -> WAIT_BLK.
- WAIT_BLK:
  - Stays until block_valid=1.
  - On that cycle: block_ack=1, last_block latched, -> COMPUTE with round=0. H is not reinitialised.
- DONE (1 cycle): done=1; -> IDLE.
- abort=1 in any state:
  - next state IDLE; round=0; no add_h or done that cycle; pulses forced 0.
  - abort has priority over every other transition.
- Start edge while busy is ignored and not queued.
- Latency, single block: done asserted ROUNDS/UNROLL+3 cycles after the start edge is sampled (83 for defaults).
- Each extra block adds ROUNDS/UNROLL+2 cycles when block_valid is already high at UPDATE exit.

Decomposition:
- Package sha1_ctrl_pkg:
  - state enum/encoding constants;
  - ROUNDS default;
  - stage length constant ROUNDS/4;
  - f_sel encodings (CH=0, PARITY=1, MAJ=2, PARITY2=3);
  - W_DIRECT_ROUNDS=16.
- Sub-module sha1_round_counter:
  - parameters ROUNDS, UNROLL;
  - inputs clear, advance;
  - outputs round, last_group, f_sel, w_load_mask.
- Sequencer contains only the FSM and pulse decode.

Test Plan:
- Defaults, one block:
  - Stimulus: start rise with last_block=1.
  - Response: init_h and block_ack at cycle 1; round 0..79 over cycles 2..81; f_sel changes at rounds 20/40/60; w_load_mask=1 for rounds 0..15; add_h at 82; done at 83; busy low at 84.
- Two blocks:
  - Stimulus: last_block=0 then 1; block_valid held low 5 cycles after the first UPDATE.
  - Response: WAIT_BLK for 5 cycles; block_ack on the cycle block_valid rises; no second init_h; exactly two add_h; one done.
- UNROLL=5:
  - round steps 0,5,...,75 (16 COMPUTE cycles).
  - w_load_mask=5'b11111 at round 10; 5'b00001 at round 15; 0 at round 20.
  - done at cycle 19.
- Abort at round 40 -> IDLE next cycle, no add_h/done. start_hash held high: no restart until it falls and rises again.
- nreset asserted mid-COMPUTE (async, between edges):
  - Response: all outputs 0 immediately; state=IDLE.
  - After release with start_hash already high: stays IDLE until a new rising edge.
